// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: computes the HI/LO result on start,
// holds the unit busy for a fixed latency, then commits HI/LO and releases D.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;

    logic             is_md_op;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_zero;
    logic             div_ovf;
    logic [31:0]      div_rt_s;
    logic [31:0]      div_rt_u;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic [31:0]      quot_u;
    logic [31:0]      rem_u;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] res_cnt;

    assign is_md_op = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);
    assign start    = is_md_op && (state == IDLE);
    assign stall_md = md_use_D && (start || busy);

    assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
    assign prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    // Dividing 0x80000000 by 1 yields exactly the required overflow result (q=0x80000000, r=0),
    // so the overflow and divide-by-zero cases both swap in a divisor of 1 and avoid X results.
    assign div_zero = (rt_E == 32'd0);
    assign div_ovf  = (rs_E == 32'h8000_0000) && (rt_E == 32'hFFFF_FFFF);
    assign div_rt_s = (div_zero || div_ovf) ? 32'd1 : rt_E;
    assign div_rt_u = div_zero ? 32'd1 : rt_E;

    assign quot_s = $signed(rs_E) / $signed(div_rt_s);
    assign rem_s  = $signed(rs_E) % $signed(div_rt_s);
    assign quot_u = rs_E / div_rt_u;
    assign rem_u  = rs_E % div_rt_u;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b0;
        res_cnt = MULT_LOAD;
        case (md_op_E)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res_hi  = rem_s;
                res_lo  = quot_s;
                res_wr  = !div_zero;
                res_cnt = DIV_LOAD;
            end
            OP_DIVU: begin
                res_hi  = rem_u;
                res_lo  = quot_u;
                res_wr  = !div_zero;
                res_cnt = DIV_LOAD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                        cnt     <= res_cnt;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (md_op_E == OP_MTHI) begin
                        hi <= rs_E;
                    end else if (md_op_E == OP_MTLO) begin
                        lo <= rs_E;
                    end
                end
                RUN: begin
                    // Any op presented while running is ignored; D is stalled so none should arrive.
                    if (cnt == '0) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler: latency, arithmetic, mthi/mtlo,
// async reset mid-operation and ops injected while busy.
module tb_md_scheduler;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op_E  (md_op_E),
        .rs_E     (rs_E),
        .rt_E     (rt_E),
        .md_use_D (md_use_D),
        .start    (start),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle, then count busy cycles (bounded) and stalled cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, output int busy_n, output int stall_n,
                         output logic start_seen);
        md_op_E  = op;
        rs_E     = a;
        rt_E     = b;
        md_use_D = use_d;
        #1;
        start_seen = start;
        stall_n    = int'(stall_md);
        busy_n     = 0;
        tick();
        md_op_E = 3'd0;
        #1;
        while (busy === 1'b1 && busy_n < 64) begin
            busy_n++;
            stall_n += int'(stall_md);
            tick();
        end
    endtask

    task automatic test_reset();
        int bn, sn;
        logic st;
        reset = 1'b1; md_op_E = 3'd0; rs_E = '0; rt_E = '0; md_use_D = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h want 0", lo); end
        #3 reset = 1'b0;
        tick();
        issue(3'd5, 32'hA5A5A5A5, 32'd0, 1'b0, bn, sn, st);
        issue(3'd6, 32'h5A5A5A5A, 32'd0, 1'b0, bn, sn, st);
        tests_run++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
            tests_failed++; $display("FAIL preload_hilo: got %h/%h want a5a5a5a5/5a5a5a5a", hi, lo); end
        // div, then reset asynchronously 3 cycles into the run
        md_op_E = 3'd3; rs_E = 32'd100; rt_E = 32'd7;
        tick();
        md_op_E = 3'd0;
        tick(); tick(); tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrun_busy: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL async_busy: got %b want 0", busy); end
        tests_run++; if (hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++; $display("FAIL async_hilo: got %h/%h want 0/0", hi, lo); end
        #2 reset = 1'b0;
        tick();
        issue(3'd1, 32'd3, 32'd4, 1'b0, bn, sn, st);
        tests_run++; if (st !== 1'b1 || bn != 5) begin
            tests_failed++; $display("FAIL post_reset_mult_lat: start %b busy %0d want 1/5", st, bn); end
        tests_run++; if (hi !== 32'd0 || lo !== 32'd12) begin
            tests_failed++; $display("FAIL post_reset_mult: got %h/%h want 0/c", hi, lo); end
    endtask

    task automatic test_mult();
        int bn, sn;
        logic st;
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, bn, sn, st);
        tests_run++; if (bn != 5) begin tests_failed++; $display("FAIL mult_busy: got %0d want 5", bn); end
        tests_run++; if (sn != 6) begin tests_failed++; $display("FAIL mult_stall: got %0d want 6", sn); end
        tests_run++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            tests_failed++; $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", hi, lo); end
        tests_run++; if (stall_md !== 1'b0) begin
            tests_failed++; $display("FAIL mult_release: stall got %b want 0", stall_md); end
        issue(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, bn, sn, st);
        tests_run++; if (bn != 5 || sn != 0) begin
            tests_failed++; $display("FAIL multu_lat: busy %0d stall %0d want 5/0", bn, sn); end
        tests_run++; if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            tests_failed++; $display("FAIL multu_result: got %h/%h want 00000002/fffffffa", hi, lo); end
    endtask

    task automatic test_div();
        int bn, sn;
        logic st;
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, bn, sn, st);
        tests_run++; if (bn != 10) begin tests_failed++; $display("FAIL div_busy: got %0d want 10", bn); end
        tests_run++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            tests_failed++; $display("FAIL div_result: got %h/%h want ffffffff/fffffffd", hi, lo); end
        issue(3'd4, 32'd7, 32'd0, 1'b0, bn, sn, st);
        tests_run++; if (bn != 10) begin tests_failed++; $display("FAIL divu0_busy: got %0d want 10", bn); end
        tests_run++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            tests_failed++; $display("FAIL divu0_keep: got %h/%h want ffffffff/fffffffd", hi, lo); end
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, bn, sn, st);
        tests_run++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
            tests_failed++; $display("FAIL div_ovf: got %h/%h want 0/80000000", hi, lo); end
        issue(3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, bn, sn, st);
        tests_run++; if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
            tests_failed++; $display("FAIL div_negdiv: got %h/%h want 1/fffffffd", hi, lo); end
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, bn, sn, st);
        tests_run++; if (hi !== 32'd1 || lo !== 32'h7FFFFFFC) begin
            tests_failed++; $display("FAIL divu_result: got %h/%h want 1/7ffffffc", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        md_op_E = 3'd5; rs_E = 32'h12345678; rt_E = 32'd0; md_use_D = 1'b1;
        #1;
        tests_run++; if (stall_md !== 1'b0 || start !== 1'b0) begin
            tests_failed++; $display("FAIL mthi_nostart: stall %b start %b want 0/0", stall_md, start); end
        tests_run++; if (hi !== 32'd1) begin tests_failed++; $display("FAIL mthi_early: got %h want 1", hi); end
        tick();
        md_op_E = 3'd0;
        #1;
        tests_run++; if (hi !== 32'h12345678 || lo !== 32'h7FFFFFFC) begin
            tests_failed++; $display("FAIL mthi_write: got %h/%h want 12345678/7ffffffc", hi, lo); end
        tests_run++; if (busy !== 1'b0 || stall_md !== 1'b0) begin
            tests_failed++; $display("FAIL mthi_busy: busy %b stall %b want 0/0", busy, stall_md); end
        md_op_E = 3'd6; rs_E = 32'hCAFEF00D; md_use_D = 1'b0;
        tick();
        md_op_E = 3'd0;
        #1;
        tests_run++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D || busy !== 1'b0) begin
            tests_failed++; $display("FAIL mtlo_write: got %h/%h busy %b want 12345678/cafef00d/0", hi, lo, busy); end
    endtask

    task automatic test_inject_while_busy();
        md_op_E = 3'd1; rs_E = 32'd6; rt_E = 32'd7; md_use_D = 1'b0;
        tick();
        md_op_E = 3'd0;
        tick();
        md_op_E = 3'd3; rs_E = 32'd100; rt_E = 32'd5;
        #1;
        tests_run++; if (start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL inject_start: start %b busy %b want 0/1", start, busy); end
        tick(); tick();
        md_op_E = 3'd0;
        tick();
        tests_run++; if (busy !== 1'b1 || lo !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL inject_precommit: busy %b lo %h want 1/cafef00d", busy, lo); end
        tick();
        tests_run++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
            tests_failed++; $display("FAIL inject_commit: busy %b got %h/%h want 0/0/2a", busy, hi, lo); end
        tick();
        tests_run++; if (busy !== 1'b0 || lo !== 32'd42) begin
            tests_failed++; $display("FAIL inject_after: busy %b lo %h want 0/2a", busy, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_inject_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
